pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipelined ARM core. Tracks the destination register and control bits of every in-flight instruction in a private shadow pipeline (E/M/W), and from that drives ALU-operand forwarding selects, fetch/decode stalls and decode/execute flushes. It also keeps saturating load-use stall and taken-branch counters for profiling. Sits beside the datapath and is fed from the decoder, the condition logic and the register-source muxes.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the pipelined ARM core control logic.
package cpu_pkg;

  // ALU operand source select; encoding matches the datapath operand muxes.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Reads of R15 return PC+8 from the register file and are never forwarded.
  localparam logic [3:0] REG_PC = 4'hF;

  // Control bits tracked per shadow stage.
  typedef struct packed {
    logic [3:0] wa3;
    logic       regwrite;
    logic       memtoreg;
    logic       pcsrc;
  } stage_ctrl_t;

  // Operand forwarding select for one E-stage source register.
  // The younger M result wins over the older W result.
  function automatic fwd_sel_t fwd_select(input logic [3:0]  ra,
                                          input stage_ctrl_t m,
                                          input stage_ctrl_t w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ra != REG_PC) begin
      if (m.regwrite && (m.wa3 == ra)) sel = FWD_M;
      else if (w.regwrite && (w.wa3 == ra)) sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count up on inc, hold at all-ones, clear on clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= '0;
    else if (clr) r_q <= '0;
    else if (inc && (r_q != {W{1'b1}})) r_q <= r_q + 1'b1;
  end

  assign q = r_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: shadow E/M/W control pipeline,
// operand forwarding, stall/flush generation and profiling counters.
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             RegWriteE,
  input  logic             BranchTakenE,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  stage_ctrl_t r_e, r_m, r_w;
  logic [3:0]  r_ra1e, r_ra2e;

  logic w_ldr_stall;
  logic w_pc_pending;
  logic w_flush_e_raw;
  logic w_unused_ok;

  // Raw hazard terms; outputs below are additionally forced low in reset.
  assign w_ldr_stall   = r_e.memtoreg & r_e.regwrite &
                         ((RA1D == r_e.wa3) | (RA2D == r_e.wa3));
  assign w_pc_pending  = PCSrcD | r_e.pcsrc | r_m.pcsrc;
  assign w_flush_e_raw = w_ldr_stall | BranchTakenE;

  // E shadow: capture the decode instruction, or a bubble when E is flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e    <= '0;
      r_ra1e <= '0;
      r_ra2e <= '0;
    end else begin
      r_ra1e <= RA1D;
      r_ra2e <= RA2D;
      r_e.wa3 <= WA3D;
      if (w_flush_e_raw) begin
        r_e.regwrite <= 1'b0;
        r_e.memtoreg <= 1'b0;
        r_e.pcsrc    <= 1'b0;
      end else begin
        r_e.regwrite <= RegWriteD;
        r_e.memtoreg <= MemtoRegD;
        r_e.pcsrc    <= PCSrcD;
      end
    end
  end

  // M and W shadows: E advances with its condition-qualified write enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_m.wa3      <= r_e.wa3;
      r_m.regwrite <= RegWriteE;
      r_m.memtoreg <= r_e.memtoreg;
      r_m.pcsrc    <= r_e.pcsrc & RegWriteE;
      r_w          <= r_m;
    end
  end

  // Load type is carried down the shadow pipe but not needed past E here.
  assign w_unused_ok = r_m.memtoreg ^ r_w.memtoreg;

  // Hazard outputs; a taken branch overrides any stall.
  assign ForwardAE = reset ? fwd_select(r_ra1e, r_m, r_w) : FWD_RF;
  assign ForwardBE = reset ? fwd_select(r_ra2e, r_m, r_w) : FWD_RF;
  assign StallD    = reset & w_ldr_stall & ~BranchTakenE;
  assign StallF    = reset & (w_ldr_stall | w_pc_pending) & ~BranchTakenE;
  assign FlushD    = reset & (w_pc_pending | r_w.pcsrc | BranchTakenE);
  assign FlushE    = reset & w_flush_e_raw;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (StallD),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (BranchTakenE & reset),
    .q     (branch_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [3:0]    RA1D, RA2D, WA3D;
  logic          RegWriteD, MemtoRegD, PCSrcD;
  logic          RegWriteE, BranchTakenE, cnt_clr;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushD, FlushE;
  logic [CW-1:0] stall_cnt, branch_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3D         (WA3D),
    .RegWriteD    (RegWriteD),
    .MemtoRegD    (MemtoRegD),
    .PCSrcD       (PCSrcD),
    .RegWriteE    (RegWriteE),
    .BranchTakenE (BranchTakenE),
    .cnt_clr      (cnt_clr),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .stall_cnt    (stall_cnt),
    .branch_cnt   (branch_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [3:0] ra1, input logic [3:0] ra2,
                         input logic [3:0] wa3, input logic rw,
                         input logic mtr, input logic pcs);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mtr; PCSrcD = pcs;
  endtask

  task automatic clear_inputs();
    drive_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    RegWriteE = 1'b0;
    BranchTakenE = 1'b0;
    cnt_clr = 1'b0;
  endtask

  // Empty the shadow pipeline and zero the counters.
  task automatic flush_pipe();
    clear_inputs();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    drive_d(4'd2, 4'd2, 4'd2, 1'b1, 1'b1, 1'b1);
    BranchTakenE = 1'b1;
    #1;
    n_total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) $display("FAIL reset_haz got %b exp 0000", {StallF, StallD, FlushD, FlushE});
    else n_pass++;
    n_total++;
    if ({ForwardAE, ForwardBE, stall_cnt, branch_cnt} !== '0) $display("FAIL reset_fwd_cnt got %h exp 0", {ForwardAE, ForwardBE, stall_cnt, branch_cnt});
    else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    clear_inputs();
    #1;
    n_total++;
    if ({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE} !== 8'h00) $display("FAIL reset_release got %h exp 00", {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE});
    else n_pass++;
  endtask

  task automatic test_forward();
    // ADD R1 then SUB reading R1: forward from M.
    flush_pipe();
    drive_d(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    RegWriteE = 1'b1;
    drive_d(4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
    tick();
    #1;
    n_total++;
    if (ForwardAE !== 2'b10) $display("FAIL fwd_m_a got %b exp 10", ForwardAE);
    else n_pass++;
    // ORR reads R1 through source B; producer now only in W.
    RegWriteE = 1'b1;
    drive_d(4'd0, 4'd1, 4'd6, 1'b1, 1'b0, 1'b0);
    tick();
    RegWriteE = 1'b0;
    drive_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_total++;
    if (ForwardBE !== 2'b01) $display("FAIL fwd_w_b got %b exp 01", ForwardBE);
    else n_pass++;
    n_total++;
    if (ForwardAE !== 2'b00) $display("FAIL fwd_none_a got %b exp 00", ForwardAE);
    else n_pass++;
    // Two writers of R1 back to back: the M one wins.
    flush_pipe();
    drive_d(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    RegWriteE = 1'b1;
    drive_d(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    RegWriteE = 1'b1;
    drive_d(4'd1, 4'd1, 4'd7, 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    #1;
    n_total++;
    if ({ForwardAE, ForwardBE} !== 4'b1010) $display("FAIL fwd_m_over_w got %b exp 1010", {ForwardAE, ForwardBE});
    else n_pass++;
    // R15 reads never forward.
    flush_pipe();
    drive_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0);
    tick();
    RegWriteE = 1'b1;
    drive_d(4'd15, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    #1;
    n_total++;
    if (ForwardAE !== 2'b00) $display("FAIL fwd_pc_none got %b exp 00", ForwardAE);
    else n_pass++;
  endtask

  task automatic test_load_use();
    flush_pipe();
    drive_d(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0);   // LDR R2
    tick();
    RegWriteE = 1'b1;
    drive_d(4'd2, 4'd4, 4'd3, 1'b1, 1'b0, 1'b0);   // ADD R3,R2,R4
    #1;
    n_total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) $display("FAIL ldr_stall got %b exp 1101", {StallF, StallD, FlushD, FlushE});
    else n_pass++;
    tick();
    RegWriteE = 1'b0;
    #1;
    n_total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) $display("FAIL ldr_release got %b exp 0000", {StallF, StallD, FlushD, FlushE});
    else n_pass++;
    n_total++;
    if (stall_cnt !== 4'd1) $display("FAIL ldr_cnt got %0d exp 1", stall_cnt);
    else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_total++;
    if ({ForwardAE, ForwardBE} !== 4'b0100) $display("FAIL ldr_fwd_w got %b exp 0100", {ForwardAE, ForwardBE});
    else n_pass++;
  endtask

  task automatic test_branch_over_stall();
    flush_pipe();
    drive_d(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0);
    tick();
    RegWriteE = 1'b1;
    BranchTakenE = 1'b1;
    drive_d(4'd2, 4'd4, 4'd3, 1'b1, 1'b0, 1'b0);
    #1;
    n_total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) $display("FAIL br_haz got %b exp 0011", {StallF, StallD, FlushD, FlushE});
    else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_total++;
    if ({branch_cnt, stall_cnt} !== {4'd1, 4'd0}) $display("FAIL br_cnt got %h exp 10", {branch_cnt, stall_cnt});
    else n_pass++;
  endtask

  task automatic test_pc_write();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b1010;
    exp_seq[1] = 4'b1010;
    exp_seq[2] = 4'b1010;
    exp_seq[3] = 4'b0010;
    exp_seq[4] = 4'b0000;
    flush_pipe();
    drive_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        tick();
        clear_inputs();
        RegWriteE = (i == 1);   // branch condition passes in E
      end
      #1;
      n_total++;
      if ({StallF, StallD, FlushD, FlushE} !== exp_seq[i]) $display("FAIL pcwr_c%0d got %b exp %b", i, {StallF, StallD, FlushD, FlushE}, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_saturate_clear_reset();
    flush_pipe();
    // LDR R2,[R2] held in D stalls on itself every other cycle.
    drive_d(4'd2, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (stall_cnt !== 4'd5) $display("FAIL sat_mid got %0d exp 5", stall_cnt);
    else n_pass++;
    for (int i = 0; i < 30; i++) tick();
    n_total++;
    if (stall_cnt !== 4'd15) $display("FAIL sat_hold got %0d exp 15", stall_cnt);
    else n_pass++;
    tick();
    n_total++;
    if (StallD !== 1'b1) $display("FAIL sat_stall got %b exp 1", StallD);
    else n_pass++;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_total++;
    if (stall_cnt !== 4'd0) $display("FAIL clr_wins got %0d exp 0", stall_cnt);
    else n_pass++;
    tick();
    n_total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) $display("FAIL pre_rst_stall got %b exp 1101", {StallF, StallD, FlushD, FlushE});
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if ({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, branch_cnt} !== '0) $display("FAIL rst_mid got %h exp 0", {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, branch_cnt});
    else n_pass++;
    tick();
    reset = 1'b1;
    #1;
    n_total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) $display("FAIL post_rst_empty got %b exp 0000", {StallF, StallD, FlushD, FlushE});
    else n_pass++;
  endtask

  // Sequence and final report
  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_branch_over_stall();
    test_pc_write();
    test_saturate_clear_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
